spi_slave_core: RTL and testbench

Parametrised SPI slave that runs on the system clock `clk` and oversamples the SPI pins; it does not clock logic from SCK.
- Supports all four CPOL/CPHA modes, configurable word width, full-duplex TX/RX with a one-word TX buffer, framing-error detection and a received-word counter.
- Sits between the board SPI pins and user logic; it is the generalised successor to the SCK-clocked bit-counter test slave.

---
 rtl/spi_slave_core.sv | 165 ++++++++++++++++
 tb/tb_spi_slave_core.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// System-clocked SPI slave: oversamples sck/ss_n/mosi, supports all CPOL/CPHA modes,
// full-duplex with a one-word TX buffer, framing-error pulse and received-word counter.
module spi_slave_core #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck,
    input  logic             ss_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_empty,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int unsigned BIT_W        = $clog2(WIDTH + 1);
    localparam logic        IDLE_LVL     = 1'(CPOL);
    localparam logic        SAMPLE_TRAIL = (CPHA != 0);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

    state_t           state, state_n;
    logic [SYNC_STAGES-1:0] sck_pipe, ss_pipe, mosi_pipe;
    logic             sck_d, ss_d;
    logic             sck_s, ss_s, mosi_s;
    logic             sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic             ss_fall, ss_rise;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] shift_tx, shift_tx_n, shift_rx, shift_rx_n;
    logic [WIDTH-1:0] tx_buf, tx_buf_n, rx_data_n, rx_word, reload_value;
    logic [CNT_W-1:0] word_cnt_n;
    logic             tx_empty_n, rx_valid_n, frame_err_n, miso_n, reload;

    assign sck_s  = sck_pipe[SYNC_STAGES-1];
    assign ss_s   = ss_pipe[SYNC_STAGES-1];
    assign mosi_s = mosi_pipe[SYNC_STAGES-1];

    assign sck_edge    = sck_s ^ sck_d;
    assign lead_edge   = sck_edge & (sck_d == IDLE_LVL);
    assign trail_edge  = sck_edge & (sck_s == IDLE_LVL);
    assign sample_edge = SAMPLE_TRAIL ? trail_edge : lead_edge;
    assign shift_edge  = SAMPLE_TRAIL ? lead_edge : trail_edge;
    assign ss_fall     = ss_d & ~ss_s;
    assign ss_rise     = ~ss_d & ss_s;

    assign rx_word      = {shift_rx[WIDTH-2:0], mosi_s};
    assign reload_value = tx_load ? tx_data : tx_buf;

    // ss pipe resets to "selected" so a frame in flight at reset must be released first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_pipe  <= {SYNC_STAGES{IDLE_LVL}};
            ss_pipe   <= '0;
            mosi_pipe <= '0;
            sck_d     <= IDLE_LVL;
            ss_d      <= 1'b0;
        end else begin
            sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], sck};
            ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], ss_n};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_s;
            ss_d      <= ss_s;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_tx_n  = shift_tx;
        shift_rx_n  = shift_rx;
        tx_buf_n    = tx_buf;
        tx_empty_n  = tx_empty;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;
        word_cnt_n  = word_cnt;
        reload      = 1'b0;

        if (tx_load) begin
            tx_buf_n   = tx_data;
            tx_empty_n = 1'b0;
        end

        unique case (state)
            WAIT_IDLE: if (ss_s) state_n = IDLE;
            IDLE: begin
                bit_cnt_n = '0;
                if (ss_fall) begin
                    state_n = ACTIVE;
                    reload  = 1'b1;
                end
            end
            ACTIVE: if (ss_rise) begin
                state_n     = IDLE;
                bit_cnt_n   = '0;
                frame_err_n = (bit_cnt != '0);
            end
            default: state_n = WAIT_IDLE;
        endcase

        // SCK edges are honoured in the same cycle an SS fall starts the frame
        if (state_n == ACTIVE) begin
            // bit_cnt==0 means the MSB is already presented; do not shift it away
            if (shift_edge && bit_cnt != '0)
                shift_tx_n = shift_tx << 1;
            if (sample_edge) begin
                shift_rx_n = rx_word;
                if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                    bit_cnt_n  = '0;
                    rx_data_n  = rx_word;
                    rx_valid_n = 1'b1;
                    word_cnt_n = word_cnt + CNT_W'(1);
                    reload     = 1'b1;
                end else begin
                    bit_cnt_n = bit_cnt + BIT_W'(1);
                end
            end
        end

        if (reload) begin
            shift_tx_n = reload_value;
            tx_empty_n = 1'b1;
        end

        miso_n = (state_n == ACTIVE) ? shift_tx_n[WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_IDLE;
            bit_cnt   <= '0;
            shift_tx  <= '0;
            shift_rx  <= '0;
            tx_buf    <= '0;
            tx_empty  <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            word_cnt  <= '0;
            miso      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift_tx  <= shift_tx_n;
            shift_rx  <= shift_rx_n;
            tx_buf    <= tx_buf_n;
            tx_empty  <= tx_empty_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            frame_err <= frame_err_n;
            word_cnt  <= word_cnt_n;
            miso      <= miso_n;
        end
    end

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: instances 0..3 run SPI modes 0..3, instance 4 is mode 0 with CNT_W=2.
module tb_spi_slave_core;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck      [5];
    logic       ss_n     [5];
    logic       mosi     [5];
    logic       miso     [5];
    logic       tx_load  [5];
    logic       tx_empty [5];
    logic [7:0] rx_data  [5];
    logic       rx_valid [5];
    logic       frame_err[5];
    logic [15:0] wc      [4];
    logic [1:0] wc4;
    logic [7:0] tx_data = 8'h00;

    int rv_cnt[5];
    int fe_cnt[5];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_core #(.WIDTH(8), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2), .CNT_W(16)) u_dut (
            .clk(clk), .rst(rst), .sck(sck[g]), .ss_n(ss_n[g]), .mosi(mosi[g]), .miso(miso[g]),
            .tx_data(tx_data), .tx_load(tx_load[g]), .tx_empty(tx_empty[g]), .rx_data(rx_data[g]),
            .rx_valid(rx_valid[g]), .frame_err(frame_err[g]), .word_cnt(wc[g])
        );
    end

    spi_slave_core #(.WIDTH(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2), .CNT_W(2)) u_dut_cnt2 (
        .clk(clk), .rst(rst), .sck(sck[4]), .ss_n(ss_n[4]), .mosi(mosi[4]), .miso(miso[4]),
        .tx_data(tx_data), .tx_load(tx_load[4]), .tx_empty(tx_empty[4]), .rx_data(rx_data[4]),
        .rx_valid(rx_valid[4]), .frame_err(frame_err[4]), .word_cnt(wc4)
    );

    initial for (int i = 0; i < 5; i++) begin rv_cnt[i] = 0; fe_cnt[i] = 0; end

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (rx_valid[i])  rv_cnt[i] <= rv_cnt[i] + 1;
            if (frame_err[i]) fe_cnt[i] <= fe_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int d, input logic [7:0] v);
        tx_data    = v;
        tx_load[d] = 1'b1;
        wait_clk(1);
        tx_load[d] = 1'b0;
    endtask

    task automatic ss_lo(input int d);
        ss_n[d] = 1'b0;
        wait_clk(H);
    endtask

    task automatic ss_hi(input int d);
        wait_clk(H);
        ss_n[d] = 1'b1;
        wait_clk(H);
    endtask

    // Master side of one word (or nbits of it); ld>=0 strobes tx_load exactly in the reload cycle
    task automatic xfer(input int d, input logic [7:0] mo, input int nbits, input bit lat,
                        input int ld, output logic [7:0] mi);
        logic cpol, cpha;
        cpol = (d == 2 || d == 3);
        cpha = (d == 1 || d == 3);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi[d] = mo[7-i];
                wait_clk(H);
                mi = {mi[6:0], miso[d]};
                sck[d] = ~cpol;
                if (i == nbits - 1 && (lat || ld >= 0)) begin
                    wait_clk(2);
                    if (lat) check("rv_before_latency", 32'(rx_valid[d]), 32'd0);
                    if (ld >= 0) begin
                        tx_data    = 8'(ld);
                        tx_load[d] = 1'b1;
                    end
                    wait_clk(1);
                    tx_load[d] = 1'b0;
                    if (lat) check("rv_at_latency", 32'(rx_valid[d]), 32'd1);
                    if (ld >= 0) check("tx_empty_coinc", 32'(tx_empty[d]), 32'd1);
                    wait_clk(H - 3);
                end else begin
                    wait_clk(H);
                end
                sck[d] = cpol;
            end else begin
                sck[d]  = ~cpol;
                mosi[d] = mo[7-i];
                wait_clk(H);
                mi = {mi[6:0], miso[d]};
                sck[d] = cpol;
                wait_clk(H);
            end
        end
    endtask

    initial begin
        logic [7:0] mi;
        int rv0, fe0;
        for (int i = 0; i < 5; i++) begin
            sck[i]     = (i == 2 || i == 3);
            ss_n[i]    = 1'b1;
            mosi[i]    = 1'b0;
            tx_load[i] = 1'b0;
        end
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);

        check("rst_miso", 32'(miso[0]), 32'd0);
        check("rst_tx_empty", 32'(tx_empty[0]), 32'd1);
        check("rst_rx_data", 32'(rx_data[0]), 32'd0);
        check("rst_rx_valid", 32'(rx_valid[0]), 32'd0);
        check("rst_frame_err", 32'(frame_err[0]), 32'd0);
        check("rst_word_cnt", 32'(wc[0]), 32'd0);

        // mode 0 single word
        load(0, 8'hA5);
        check("m0_tx_empty_loaded", 32'(tx_empty[0]), 32'd0);
        rv0 = rv_cnt[0];
        ss_lo(0);
        xfer(0, 8'h3C, 8, 1'b1, -1, mi);
        ss_hi(0);
        check("m0_master_rx", 32'(mi), 32'hA5);
        check("m0_rx_data", 32'(rx_data[0]), 32'h3C);
        check("m0_rv_pulses", 32'(rv_cnt[0] - rv0), 32'd1);
        check("m0_word_cnt", 32'(wc[0]), 32'd1);
        check("m0_tx_empty_after", 32'(tx_empty[0]), 32'd1);

        // modes 1..3
        for (int d = 1; d < 4; d++) begin
            load(d, 8'h81);
            check("mode_miso_desel_pre", 32'(miso[d]), 32'd0);
            ss_lo(d);
            xfer(d, 8'h7E, 8, 1'b0, -1, mi);
            ss_hi(d);
            check("mode_master_rx", 32'(mi), 32'h81);
            check("mode_rx_data", 32'(rx_data[d]), 32'h7E);
            check("mode_word_cnt", 32'(wc[d]), 32'd1);
            check("mode_miso_desel_post", 32'(miso[d]), 32'd0);
        end

        // back-to-back words, stale buffer re-sent
        load(0, 8'hF0);
        rv0 = rv_cnt[0];
        ss_lo(0);
        xfer(0, 8'h01, 8, 1'b0, -1, mi);
        check("b2b_w1_master", 32'(mi), 32'hF0);
        check("b2b_w1_rx", 32'(rx_data[0]), 32'h01);
        check("b2b_w1_tx_empty", 32'(tx_empty[0]), 32'd1);
        xfer(0, 8'h02, 8, 1'b0, -1, mi);
        check("b2b_w2_master", 32'(mi), 32'hF0);
        check("b2b_w2_rx", 32'(rx_data[0]), 32'h02);
        xfer(0, 8'h03, 8, 1'b0, -1, mi);
        check("b2b_w3_master", 32'(mi), 32'hF0);
        ss_hi(0);
        check("b2b_rx_data", 32'(rx_data[0]), 32'h03);
        check("b2b_rv_pulses", 32'(rv_cnt[0] - rv0), 32'd3);
        check("b2b_word_cnt", 32'(wc[0]), 32'd4);

        // framing error after 5 bits
        fe0 = fe_cnt[0];
        rv0 = rv_cnt[0];
        ss_lo(0);
        xfer(0, 8'hFF, 5, 1'b0, -1, mi);
        ss_hi(0);
        check("fe_pulses", 32'(fe_cnt[0] - fe0), 32'd1);
        check("fe_no_rv", 32'(rv_cnt[0] - rv0), 32'd0);
        check("fe_rx_kept", 32'(rx_data[0]), 32'h03);
        check("fe_word_cnt", 32'(wc[0]), 32'd4);
        ss_lo(0);
        xfer(0, 8'h55, 8, 1'b0, -1, mi);
        ss_hi(0);
        check("fe_next_rx", 32'(rx_data[0]), 32'h55);
        check("fe_next_master", 32'(mi), 32'hF0);
        check("fe_next_word_cnt", 32'(wc[0]), 32'd5);

        // reset in the middle of a word with ss_n held low
        ss_lo(0);
        xfer(0, 8'hAA, 4, 1'b0, -1, mi);
        rst = 1'b1;
        wait_clk(2);
        check("mid_rst_rx_data", 32'(rx_data[0]), 32'd0);
        check("mid_rst_word_cnt", 32'(wc[0]), 32'd0);
        check("mid_rst_tx_empty", 32'(tx_empty[0]), 32'd1);
        check("mid_rst_miso", 32'(miso[0]), 32'd0);
        rst = 1'b0;
        rv0 = rv_cnt[0];
        xfer(0, 8'hAA, 4, 1'b0, -1, mi);
        wait_clk(H);
        check("post_rst_no_rv", 32'(rv_cnt[0] - rv0), 32'd0);
        check("post_rst_word_cnt", 32'(wc[0]), 32'd0);
        ss_hi(0);
        ss_lo(0);
        xfer(0, 8'hC3, 8, 1'b0, -1, mi);
        ss_hi(0);
        check("post_rst_rx", 32'(rx_data[0]), 32'hC3);
        check("post_rst_word_cnt2", 32'(wc[0]), 32'd1);

        // CNT_W=2 wrap plus tx_load in the reload cycle
        load(4, 8'h11);
        ss_lo(4);
        xfer(4, 8'h10, 8, 1'b1, 8'h22, mi);
        check("c2_w1_master", 32'(mi), 32'h11);
        check("c2_w1_rx", 32'(rx_data[4]), 32'h10);
        check("c2_cnt1", 32'(wc4), 32'd1);
        xfer(4, 8'h20, 8, 1'b0, -1, mi);
        check("c2_w2_master_coinc", 32'(mi), 32'h22);
        check("c2_cnt2", 32'(wc4), 32'd2);
        xfer(4, 8'h30, 8, 1'b0, -1, mi);
        check("c2_w3_master_stale", 32'(mi), 32'h22);
        check("c2_cnt3", 32'(wc4), 32'd3);
        xfer(4, 8'h40, 8, 1'b0, -1, mi);
        check("c2_cnt_wrap0", 32'(wc4), 32'd0);
        xfer(4, 8'h50, 8, 1'b0, -1, mi);
        check("c2_cnt_wrap1", 32'(wc4), 32'd1);
        check("c2_w5_rx", 32'(rx_data[4]), 32'h50);
        ss_hi(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
